beta_lsu: RTL and testbench

BETA_LSU -- requirements
Module: beta_lsu

---
 rtl/beta_pkg.sv | 14 +
 rtl/beta_lsu_if.sv | 24 ++
 rtl/beta_lsu.sv | 161 ++++++++++++++++
 tb/tb_beta_lsu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// beta_pkg: shared LSU encodings for the beta core.
//   MEM_*_OP    : load/store select carried on mem_op_i
//   MEM_SIZE_*  : access size carried on mem_op_size_i (2'b11 is illegal)
package beta_pkg;
  typedef logic       mem_op_t;
  typedef logic [1:0] mem_size_t;

  localparam mem_op_t   MEM_LOAD_OP    = 1'b0;
  localparam mem_op_t   MEM_STORE_OP   = 1'b1;

  localparam mem_size_t MEM_SIZE_BYTE  = 2'b00;
  localparam mem_size_t MEM_SIZE_HALF  = 2'b01;
  localparam mem_size_t MEM_SIZE_WORD  = 2'b10;
endpackage

// File: rtl/beta_lsu_if.sv
// beta_lsu_if: 32-bit data bus between the LSU and memory.
//   master (LSU)   : drives data_req/we/be/addr/wdata, receives gnt/rvalid/rdata
//   slave  (memory): the mirror image
// A request is held until data_gnt; every granted transaction, load or
// store, completes with exactly one data_rvalid.
interface beta_lsu_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );
  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/beta_lsu.sv
// beta_lsu: single-outstanding load/store unit.
//   clk_i, rstn_i          : clock, async active-low reset
//   mem_op_en_i/mem_op_i/mem_op_size_i/not_sign_ext_i/addr_i/wdata_i/rd_i
//                          : memory op from execute (accepted only when idle)
//   busy_o                 : LSU occupied, execute holds its next op
//   bus (master)           : data bus request/grant/response
//   wb_valid_o/wb_data_o/wb_rd_o : one-cycle load writeback
//   misaligned_o           : one-cycle pulse for an illegal or misaligned op
module beta_lsu
  import beta_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              mem_op_en_i,
  input  mem_op_t           mem_op_i,
  input  mem_size_t         mem_op_size_i,
  input  logic              not_sign_ext_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_i,
  output logic              busy_o,
  beta_lsu_if.master        bus,
  output logic              wb_valid_o,
  output logic [31:0]       wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic              misaligned_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_e;

  state_e      state_q, state_d;
  mem_op_t     op_q;
  mem_size_t   size_q;
  logic        ext_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wb_valid_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        misaligned_q;

  logic        accept;
  logic        illegal;
  logic        start;
  logic        rsp;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rshift;
  logic [31:0] ld_data;

  // Only IDLE accepts; an op arriving while busy is dropped, not queued.
  assign accept  = (state_q == IDLE) && mem_op_en_i;
  assign illegal = (mem_op_size_i == 2'b11) ||
                   ((mem_op_size_i == MEM_SIZE_HALF) && addr_i[0]) ||
                   ((mem_op_size_i == MEM_SIZE_WORD) && (addr_i[1:0] != 2'b00));
  assign start   = accept && !illegal;
  // Responses outside WAIT are stray (e.g. left over from before a reset).
  assign rsp     = (state_q == WAIT) && bus.data_rvalid;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)            state_d = REQ;
      REQ:     if (bus.data_gnt)     state_d = WAIT;
      WAIT:    if (bus.data_rvalid)  state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // ---------------- command formatting ----------------
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    case (mem_op_size_i)
      MEM_SIZE_BYTE: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      MEM_SIZE_HALF: begin
        be_d    = 4'b0011 << addr_i[1:0];
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // ---------------- load data alignment / extension ----------------
  always_comb begin
    rshift  = bus.data_rdata >> {off_q, 3'b000};
    ld_data = rshift;
    case (size_q)
      MEM_SIZE_BYTE: ld_data = ext_q ? {24'h0, rshift[7:0]}
                                     : {{24{rshift[7]}}, rshift[7:0]};
      MEM_SIZE_HALF: ld_data = ext_q ? {16'h0, rshift[15:0]}
                                     : {{16{rshift[15]}}, rshift[15:0]};
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  // Command registers load only on acceptance, so they stay stable
  // for the whole REQ phase however long the grant takes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      op_q         <= MEM_LOAD_OP;
      size_q       <= MEM_SIZE_BYTE;
      ext_q        <= 1'b0;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      we_q         <= 1'b0;
      be_q         <= 4'b0000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= 32'h0;
      wb_rd_q      <= 5'd0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= accept && illegal;
      wb_valid_q   <= 1'b0;
      if (start) begin
        op_q    <= mem_op_i;
        size_q  <= mem_op_size_i;
        ext_q   <= not_sign_ext_i;
        off_q   <= addr_i[1:0];
        rd_q    <= rd_i;
        we_q    <= (mem_op_i == MEM_STORE_OP);
        be_q    <= be_d;
        addr_q  <= {addr_i[31:2], 2'b00};
        wdata_q <= wdata_d;
      end
      if (rsp && (op_q == MEM_LOAD_OP)) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= ld_data;
        wb_rd_q    <= rd_q;
      end
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign bus.data_req   = (state_q == REQ);
  assign bus.data_we    = we_q;
  assign bus.data_be    = be_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_data_o      = wb_data_q;
  assign wb_rd_o        = wb_rd_q;
  assign misaligned_o   = misaligned_q;

endmodule

// File: tb/tb_beta_lsu.sv
// tb_beta_lsu: directed self-checking bench for beta_lsu; the bench plays
// the memory side of the bus and drives inputs #1 after each rising edge.
module tb_beta_lsu;
  import beta_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        mem_op_en_i;
  mem_op_t     mem_op_i;
  mem_size_t   mem_op_size_i;
  logic        not_sign_ext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        busy_o;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        misaligned_o;

  int n_pass  = 0;
  int n_total = 0;

  beta_lsu_if bus();

  beta_lsu dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .mem_op_en_i(mem_op_en_i), .mem_op_i(mem_op_i), .mem_op_size_i(mem_op_size_i),
    .not_sign_ext_i(not_sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .busy_o(busy_o), .bus(bus),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
    .misaligned_o(misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i); #1;
  endtask

  task automatic issue(input mem_op_t op, input mem_size_t sz, input logic ext,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    mem_op_en_i = 1'b1; mem_op_i = op; mem_op_size_i = sz;
    not_sign_ext_i = ext; addr_i = a; wdata_i = wd; rd_i = rd;
  endtask

  task automatic test_reset;
    rstn_i = 1'b0; mem_op_en_i = 1'b0; mem_op_i = MEM_LOAD_OP; mem_op_size_i = MEM_SIZE_BYTE;
    not_sign_ext_i = 1'b0; addr_i = '0; wdata_i = '0; rd_i = '0;
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0; bus.data_rdata = '0;
    tick; tick;
    n_total++; if ({busy_o, bus.data_req, bus.data_we, wb_valid_o, misaligned_o} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000", {busy_o, bus.data_req, bus.data_we, wb_valid_o, misaligned_o}); else n_pass++;
    n_total++; if ({bus.data_be, bus.data_addr, bus.data_wdata, wb_data_o, wb_rd_o} !== '0)
      $display("FAIL reset_data got be=%h addr=%h wdata=%h wb=%h rd=%0d want all 0",
               bus.data_be, bus.data_addr, bus.data_wdata, wb_data_o, wb_rd_o); else n_pass++;
    rstn_i = 1'b1;
    tick;
  endtask

  task automatic test_lw;
    issue(MEM_LOAD_OP, MEM_SIZE_WORD, 1'b0, 32'h100, 32'h0, 5'd5);
    tick;                                   // T+1
    mem_op_en_i = 1'b0;
    n_total++; if ({bus.data_req, busy_o, bus.data_we} !== 3'b110)
      $display("FAIL lw_req got req/busy/we=%b want 110", {bus.data_req, busy_o, bus.data_we}); else n_pass++;
    n_total++; if (bus.data_be !== 4'b1111 || bus.data_addr !== 32'h100)
      $display("FAIL lw_cmd got be=%b addr=%h want 1111 00000100", bus.data_be, bus.data_addr); else n_pass++;
    bus.data_gnt = 1'b1;
    tick;                                   // T+2
    bus.data_gnt = 1'b0;
    n_total++; if (bus.data_req !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL lw_wait got req=%b busy=%b want 0 1", bus.data_req, busy_o); else n_pass++;
    bus.data_rvalid = 1'b1; bus.data_rdata = 32'hDEADBEEF;
    tick;                                   // T+3
    bus.data_rvalid = 1'b0;
    n_total++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hDEADBEEF || wb_rd_o !== 5'd5 || busy_o !== 1'b0)
      $display("FAIL lw_wb got v=%b data=%h rd=%0d busy=%b want 1 deadbeef 5 0", wb_valid_o, wb_data_o, wb_rd_o, busy_o); else n_pass++;
    tick;
    n_total++; if (wb_valid_o !== 1'b0)
      $display("FAIL lw_wb_pulse got %b want 0", wb_valid_o); else n_pass++;
  endtask

  task automatic test_lb_lbu;
    logic [31:0] exp_wb [2];
    exp_wb[0] = 32'hFFFFFF80; exp_wb[1] = 32'h00000080;
    for (int i = 0; i < 2; i++) begin
      issue(MEM_LOAD_OP, MEM_SIZE_BYTE, (i == 1), 32'h203, 32'h0, 5'd7);
      tick;
      mem_op_en_i = 1'b0;
      n_total++; if (bus.data_req !== 1'b1 || bus.data_be !== 4'b1000 || bus.data_addr !== 32'h200)
        $display("FAIL lb_cmd%0d got req=%b be=%b addr=%h want 1 1000 00000200", i, bus.data_req, bus.data_be, bus.data_addr); else n_pass++;
      bus.data_gnt = 1'b1;
      tick;
      bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1; bus.data_rdata = 32'h80FF0000;
      tick;
      bus.data_rvalid = 1'b0;
      n_total++; if (wb_valid_o !== 1'b1 || wb_data_o !== exp_wb[i] || wb_rd_o !== 5'd7)
        $display("FAIL lb_wb%0d got v=%b data=%h rd=%0d want 1 %h 7", i, wb_valid_o, wb_data_o, wb_rd_o, exp_wb[i]); else n_pass++;
    end
    tick;
  endtask

  task automatic test_sh_delayed_gnt;
    issue(MEM_STORE_OP, MEM_SIZE_HALF, 1'b0, 32'h402, 32'h1234ABCD, 5'd0);
    tick;
    mem_op_en_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_total++; if (bus.data_req !== 1'b1 || bus.data_we !== 1'b1 || bus.data_be !== 4'b1100 ||
                     bus.data_addr !== 32'h400 || bus.data_wdata !== 32'hABCDABCD)
        $display("FAIL sh_hold%0d got req=%b we=%b be=%b addr=%h wdata=%h want 1 1 1100 00000400 abcdabcd",
                 c, bus.data_req, bus.data_we, bus.data_be, bus.data_addr, bus.data_wdata); else n_pass++;
      bus.data_gnt = (c == 3);
      tick;
    end
    bus.data_gnt = 1'b0;
    n_total++; if (bus.data_req !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL sh_wait got req=%b busy=%b want 0 1", bus.data_req, busy_o); else n_pass++;
    bus.data_rvalid = 1'b1; bus.data_rdata = 32'h0;
    tick;
    bus.data_rvalid = 1'b0;
    n_total++; if (wb_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL sh_no_wb got wb_valid=%b busy=%b want 0 0", wb_valid_o, busy_o); else n_pass++;
    tick;
  endtask

  task automatic test_misaligned;
    logic [31:0] a [2];
    mem_size_t   s [2];
    a[0] = 32'h101; s[0] = MEM_SIZE_WORD;
    a[1] = 32'h0FF; s[1] = MEM_SIZE_HALF;
    for (int i = 0; i < 2; i++) begin
      issue(MEM_LOAD_OP, s[i], 1'b0, a[i], 32'h0, 5'd3);
      tick;
      mem_op_en_i = 1'b0;
      n_total++; if ({misaligned_o, bus.data_req, busy_o} !== 3'b100)
        $display("FAIL mis_pulse%0d got mis/req/busy=%b want 100", i, {misaligned_o, bus.data_req, busy_o}); else n_pass++;
      tick;
      n_total++; if ({misaligned_o, bus.data_req, busy_o} !== 3'b000)
        $display("FAIL mis_after%0d got mis/req/busy=%b want 000", i, {misaligned_o, bus.data_req, busy_o}); else n_pass++;
    end
  endtask

  task automatic test_reset_in_wait;
    issue(MEM_LOAD_OP, MEM_SIZE_WORD, 1'b0, 32'h300, 32'h0, 5'd9);
    tick;
    mem_op_en_i = 1'b0; bus.data_gnt = 1'b1;
    tick;
    bus.data_gnt = 1'b0;
    n_total++; if (busy_o !== 1'b1)
      $display("FAIL rst_wait_pre got busy=%b want 1", busy_o); else n_pass++;
    rstn_i = 1'b0;
    #1;
    n_total++; if ({busy_o, bus.data_req, bus.data_we, bus.data_be, bus.data_addr, bus.data_wdata,
                    wb_valid_o, wb_data_o, wb_rd_o, misaligned_o} !== '0)
      $display("FAIL rst_wait_clear got busy=%b req=%b be=%b addr=%h wb=%b want all 0",
               busy_o, bus.data_req, bus.data_be, bus.data_addr, wb_valid_o); else n_pass++;
    tick;
    rstn_i = 1'b1; bus.data_rvalid = 1'b1; bus.data_rdata = 32'h12345678;
    tick;
    bus.data_rvalid = 1'b0;
    n_total++; if ({wb_valid_o, busy_o, bus.data_req} !== 3'b000 || wb_data_o !== 32'h0)
      $display("FAIL rst_stray_rvalid got wb/busy/req=%b data=%h want 000 00000000",
               {wb_valid_o, busy_o, bus.data_req}, wb_data_o); else n_pass++;
    tick;
  endtask

  task automatic test_busy_ignore;
    issue(MEM_LOAD_OP, MEM_SIZE_WORD, 1'b0, 32'h100, 32'h0, 5'd5);
    tick;
    // While in REQ: a second op and a stray rvalid both arrive.
    issue(MEM_STORE_OP, MEM_SIZE_WORD, 1'b0, 32'h800, 32'hCAFEF00D, 5'd1);
    bus.data_rvalid = 1'b1; bus.data_rdata = 32'h11111111;
    tick;
    mem_op_en_i = 1'b0; bus.data_rvalid = 1'b0;
    n_total++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h100 || bus.data_we !== 1'b0 || wb_valid_o !== 1'b0)
      $display("FAIL busy_hold got req=%b addr=%h we=%b wb=%b want 1 00000100 0 0",
               bus.data_req, bus.data_addr, bus.data_we, wb_valid_o); else n_pass++;
    bus.data_gnt = 1'b1;
    tick;
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1; bus.data_rdata = 32'h0BADF00D;
    tick;
    bus.data_rvalid = 1'b0;
    n_total++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0BADF00D || wb_rd_o !== 5'd5)
      $display("FAIL busy_wb got v=%b data=%h rd=%0d want 1 0badf00d 5", wb_valid_o, wb_data_o, wb_rd_o); else n_pass++;
    tick;
    n_total++; if (busy_o !== 1'b0 || bus.data_req !== 1'b0)
      $display("FAIL busy_not_queued got busy=%b req=%b want 0 0", busy_o, bus.data_req); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_lw;
    test_lb_lbu;
    test_sh_delayed_gnt;
    test_misaligned;
    test_reset_in_wait;
    test_busy_ignore;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
